// File: rtl/fifo_2clock_cascade.sv
// Three-stage cascaded FIFO: short input stage, deep main stage, short output stage.
// Every handshake output is derived from stage state only, never from the opposite ready input.
module fifo_2clock_cascade_stage #(
  parameter int WIDTH = 36,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rd,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [0:(2**AW)-1];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_wr;
  logic             w_do_rd;

  // The extra pointer MSB separates full from empty when the low bits match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && !o_empty;

  // Read and write pointers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage array, left unreset
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

module fifo_2clock_cascade #(
  parameter int WIDTH      = 36,
  parameter int SIZE       = 9,
  parameter int SHORT_SIZE = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] datain,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [15:0]      space,
  output logic [WIDTH-1:0] dataout,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i,
  output logic [15:0]      occupied
);

  localparam logic [15:0] CAP = 16'((2**SIZE) + 2*(2**SHORT_SIZE));

  logic             w_in_full,   w_in_empty;
  logic             w_main_full, w_main_empty;
  logic             w_out_full,  w_out_empty;
  logic [WIDTH-1:0] w_in_head,   w_main_head, w_out_head;
  logic             w_wr, w_mv1, w_mv2, w_rd;
  logic [15:0]      w_occ_next;
  logic             r_live;
  logic [15:0]      r_occupied;
  logic [15:0]      r_space;
  logic [WIDTH-1:0] r_last;

  // r_live keeps dst_rdy_o low until the first edge after reset release.
  assign dst_rdy_o = r_live && !w_in_full;
  assign src_rdy_o = !w_out_empty;
  assign w_wr      = src_rdy_i && dst_rdy_o;
  assign w_mv1     = !w_in_empty && !w_main_full;
  assign w_mv2     = !w_main_empty && !w_out_full;
  assign w_rd      = src_rdy_o && dst_rdy_i;
  assign dataout   = src_rdy_o ? w_out_head : r_last;
  assign occupied  = r_occupied;
  assign space     = r_space;

  fifo_2clock_cascade_stage #(.WIDTH(WIDTH), .AW(SHORT_SIZE)) u_in (
    .clk(clk), .arst_n(arst_n), .i_wr(w_wr), .i_data(datain), .i_rd(w_mv1),
    .o_full(w_in_full), .o_empty(w_in_empty), .o_head(w_in_head)
  );

  fifo_2clock_cascade_stage #(.WIDTH(WIDTH), .AW(SIZE)) u_main (
    .clk(clk), .arst_n(arst_n), .i_wr(w_mv1), .i_data(w_in_head), .i_rd(w_mv2),
    .o_full(w_main_full), .o_empty(w_main_empty), .o_head(w_main_head)
  );

  fifo_2clock_cascade_stage #(.WIDTH(WIDTH), .AW(SHORT_SIZE)) u_out (
    .clk(clk), .arst_n(arst_n), .i_wr(w_mv2), .i_data(w_main_head), .i_rd(w_rd),
    .o_full(w_out_full), .o_empty(w_out_empty), .o_head(w_out_head)
  );

  // Internal moves cancel out, so only the external transfers change occupancy.
  always_comb begin
    w_occ_next = r_occupied;
    case ({w_wr, w_rd})
      2'b10:   w_occ_next = r_occupied + 16'd1;
      2'b01:   w_occ_next = r_occupied - 16'd1;
      default: w_occ_next = r_occupied;
    endcase
  end

  // Occupancy, space, liveness and last-read word registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_live     <= 1'b0;
      r_occupied <= 16'd0;
      r_space    <= 16'd0;
      r_last     <= '0;
    end else begin
      r_live     <= 1'b1;
      r_occupied <= w_occ_next;
      r_space    <= CAP - w_occ_next;
      if (w_rd) r_last <= w_out_head;
    end
  end

endmodule

// File: tb/tb_fifo_2clock_cascade.sv
// Directed bench for fifo_2clock_cascade: reset, fill, drain, streaming, backpressure, mid-run reset.
module tb_fifo_2clock_cascade;

  localparam int CAP = 544;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [35:0] datain = 36'd0;
  logic        src_rdy_i = 1'b0;
  logic        dst_rdy_o;
  logic [15:0] space;
  logic [35:0] dataout;
  logic        src_rdy_o;
  logic        dst_rdy_i = 1'b0;
  logic [15:0] occupied;

  int          checks = 0;
  int          failures = 0;
  logic [35:0] q[$];
  logic [35:0] next_val = 36'd0;
  int          accepted = 0;

  always #5 clk = ~clk;

  fifo_2clock_cascade dut (
    .clk(clk), .arst_n(arst_n), .datain(datain), .src_rdy_i(src_rdy_i),
    .dst_rdy_o(dst_rdy_o), .space(space), .dataout(dataout), .src_rdy_o(src_rdy_o),
    .dst_rdy_i(dst_rdy_i), .occupied(occupied)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle with scoreboard bookkeeping; inputs are set 1 ns after the edge.
  task automatic cyc(input logic s, input logic d);
    logic will_wr;
    logic will_rd;
    src_rdy_i = s;
    dst_rdy_i = d;
    datain    = next_val;
    will_wr   = s && dst_rdy_o;
    will_rd   = d && src_rdy_o;
    if (will_rd) begin
      chk("rd_nonempty_model", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        chk("rd_data", 64'(dataout), 64'(q[0]));
        void'(q.pop_front());
      end
    end
    if (will_wr) begin
      q.push_back(datain);
      next_val = next_val + 36'd1;
      accepted++;
    end
    step();
    chk("occupied", 64'(occupied), 64'(q.size()));
    chk("occ_plus_space", 64'(occupied) + 64'(space), 64'(CAP));
  endtask

  initial begin
    // Reset held for 100 ns
    #100;
    chk("rst_dst_rdy", 64'(dst_rdy_o), 64'd0);
    chk("rst_src_rdy", 64'(src_rdy_o), 64'd0);
    chk("rst_occupied", 64'(occupied), 64'd0);
    chk("rst_space", 64'(space), 64'd0);
    chk("rst_dataout", 64'(dataout), 64'd0);
    #2 arst_n = 1'b1;
    step();
    chk("post_rst_dst_rdy", 64'(dst_rdy_o), 64'd1);
    chk("post_rst_space", 64'(space), 64'd544);
    chk("post_rst_occupied", 64'(occupied), 64'd0);

    // Fill with no reads; presenting more than CAP words must stall at 544
    accepted = 0;
    for (int i = 0; i < 560; i++) cyc(1'b1, 1'b0);
    chk("fill_accepted", 64'(accepted), 64'd544);
    chk("fill_dst_rdy", 64'(dst_rdy_o), 64'd0);
    chk("fill_occupied", 64'(occupied), 64'd544);
    chk("fill_space", 64'(space), 64'd0);
    chk("fill_head", 64'(dataout), 64'd0);

    // Drain: 0..543 with no bubbles
    for (int i = 0; i < 544; i++) begin
      chk("drain_valid", 64'(src_rdy_o), 64'd1);
      chk("drain_seq", 64'(dataout), 64'(i));
      cyc(1'b0, 1'b1);
    end
    chk("drain_src_rdy", 64'(src_rdy_o), 64'd0);
    chk("drain_occupied", 64'(occupied), 64'd0);
    chk("drain_space", 64'(space), 64'd544);
    chk("drain_hold_last", 64'(dataout), 64'd543);
    chk("drain_dst_rdy", 64'(dst_rdy_o), 64'd1);

    // Streaming into an empty FIFO: word crosses one stage per edge
    next_val = 36'h0_0000_1000;
    cyc(1'b1, 1'b1);
    chk("stream_lat1_src_rdy", 64'(src_rdy_o), 64'd0);
    cyc(1'b1, 1'b1);
    chk("stream_lat2_src_rdy", 64'(src_rdy_o), 64'd0);
    cyc(1'b1, 1'b1);
    chk("stream_lat3_src_rdy", 64'(src_rdy_o), 64'd1);
    chk("stream_first_word", 64'(dataout), 64'h1000);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1);
      chk("stream_occ3", 64'(occupied), 64'd3);
      chk("stream_word", 64'(dataout), 64'h1001 + 64'(i));
      chk("stream_dst_rdy", 64'(dst_rdy_o), 64'd1);
    end

    // Random backpressure on both sides
    for (int i = 0; i < 5000; i++) cyc(1'(($urandom_range(0, 99) < 60)), 1'(($urandom_range(0, 99) < 45)));
    for (int i = 0; i < 600; i++) cyc(1'b0, 1'b1);
    chk("bp_empty_model", 64'(q.size()), 64'd0);
    chk("bp_src_rdy", 64'(src_rdy_o), 64'd0);

    // Mid-operation reset with 100 words stored
    next_val = 36'h0_0000_2000;
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0);
    chk("mid_occ100", 64'(occupied), 64'd100);
    src_rdy_i = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    chk("mid_async_dst_rdy", 64'(dst_rdy_o), 64'd0);
    chk("mid_async_src_rdy", 64'(src_rdy_o), 64'd0);
    chk("mid_async_occupied", 64'(occupied), 64'd0);
    chk("mid_async_space", 64'(space), 64'd0);
    chk("mid_async_dataout", 64'(dataout), 64'd0);
    q.delete();
    step();
    step();
    #2 arst_n = 1'b1;
    step();
    chk("mid_post_dst_rdy", 64'(dst_rdy_o), 64'd1);
    chk("mid_post_space", 64'(space), 64'd544);
    chk("mid_post_src_rdy", 64'(src_rdy_o), 64'd0);
    next_val = 36'h9_ABCD_1234;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
    chk("mid_next_read_model", 64'(q.size()), 64'd0);
    chk("mid_next_read_word", 64'(dataout), 64'h9_ABCD_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
